// File: rtl/uart_frame_pkg.sv
// rtl/uart_frame_pkg.sv - shared states, error codes and checksum helper for uart_frame_ctrl
package uart_frame_pkg;

  // FSM encoding kept as plain constants so older tools and logs read the same values
  typedef logic [2:0] state_t;
  localparam state_t S_HUNT    = 3'd0;
  localparam state_t S_LEN     = 3'd1;
  localparam state_t S_PAYLOAD = 3'd2;
  localparam state_t S_CHECK   = 3'd3;
  localparam state_t S_DRAIN   = 3'd4;

  // Rejection reasons reported on err_code
  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_CHK  = 2'd1;
  localparam logic [1:0] ERR_LEN  = 2'd2;
  localparam logic [1:0] ERR_TMO  = 2'd3;

  localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;

  // Frame checksum is a plain 8-bit wrapping sum
  function automatic logic [7:0] chk_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

endpackage

// File: rtl/frame_buf.sv
// rtl/frame_buf.sv - payload register array, one write port and one asynchronous read port
module frame_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem [DEPTH];

  // Payload storage; contents are don't-care after reset so no reset is applied
  always_ff @(posedge clk) begin
    if (wr_en && (wr_addr < AW'(DEPTH))) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read-ahead address may point one past the frame; out-of-range reads return zero
  always_comb begin
    rd_data = 8'h00;
    if (rd_addr < AW'(DEPTH)) begin
      rd_data = mem[rd_addr];
    end
  end

endmodule

// File: rtl/uart_frame_ctrl.sv
// rtl/uart_frame_ctrl.sv - sync hunt, length/checksum validation and payload drain (optional UART_FRAME_TIMEOUT_EN)
module uart_frame_ctrl
  import uart_frame_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE   = DEF_SYNC_BYTE,
  parameter int         MAX_LEN     = 16,
  parameter int         TIMEOUT_CYC = 12000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rcv,
  input  logic [7:0] rx_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic       frame_ok,
  output logic       err,
  output logic [1:0] err_code,
  output logic       ovr,
  output logic       busy
);

  localparam int         LW        = $clog2(MAX_LEN + 1);
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  state_t        state, state_nxt;
  logic [LW-1:0] len, wr_idx, rd_idx;
  logic [7:0]    acc;
  logic          len_bad, chk_match, xfer, tmo_expire;
  logic          buf_wr_en;
  logic [LW-1:0] buf_rd_addr;
  logic [7:0]    buf_rd_data;

  assign len_bad   = (rx_data == 8'h00) || (rx_data > MAX_LEN_B);
  assign chk_match = (rx_data == acc);
  assign xfer      = out_valid && out_ready;
  assign buf_wr_en = (state == S_PAYLOAD) && rcv;
  // In CHECK fetch byte 0; in DRAIN fetch the byte after the one being presented
  assign buf_rd_addr = (state == S_DRAIN) ? (rd_idx + LW'(1)) : '0;

  frame_buf #(
    .DEPTH (MAX_LEN),
    .AW    (LW)
  ) u_buf (
    .clk     (clk),
    .wr_en   (buf_wr_en),
    .wr_addr (wr_idx),
    .wr_data (rx_data),
    .rd_addr (buf_rd_addr),
    .rd_data (buf_rd_data)
  );

`ifdef UART_FRAME_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_cnt;
  logic          tmo_active;

  assign tmo_active = (state == S_LEN) || (state == S_PAYLOAD) || (state == S_CHECK);
  // A byte arriving on the expiry cycle takes priority over the timeout
  assign tmo_expire = tmo_active && !rcv && (tmo_cnt == TW'(TIMEOUT_CYC - 1));

  // Counts idle cycles inside a frame; any byte or leaving the frame states clears it
  always_ff @(posedge clk) begin
    if (!rstn || !tmo_active || rcv || tmo_expire) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + TW'(1);
    end
  end
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = (TIMEOUT_CYC != 0);
  assign tmo_expire     = 1'b0;
`endif

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      S_HUNT:    if (rcv && (rx_data == SYNC_BYTE)) state_nxt = S_LEN;
      S_LEN:     if (rcv) state_nxt = len_bad ? S_HUNT : S_PAYLOAD;
      S_PAYLOAD: if (rcv && ((wr_idx + LW'(1)) == len)) state_nxt = S_CHECK;
      S_CHECK:   if (rcv) state_nxt = chk_match ? S_DRAIN : S_HUNT;
      S_DRAIN:   if (xfer && out_last) state_nxt = S_HUNT;
      default:   state_nxt = S_HUNT;
    endcase
    if (tmo_expire) state_nxt = S_HUNT;
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= S_HUNT;
      len       <= '0;
      wr_idx    <= '0;
      rd_idx    <= '0;
      acc       <= 8'h00;
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      out_last  <= 1'b0;
      frame_ok  <= 1'b0;
      err       <= 1'b0;
      err_code  <= ERR_NONE;
      ovr       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state    <= state_nxt;
      busy     <= (state_nxt != S_HUNT);
      frame_ok <= 1'b0;
      err      <= 1'b0;
      ovr      <= 1'b0;
      if (tmo_expire) begin
        err      <= 1'b1;
        err_code <= ERR_TMO;
      end else begin
        case (state)
          S_LEN: begin
            if (rcv) begin
              if (len_bad) begin
                err      <= 1'b1;
                err_code <= ERR_LEN;
              end else begin
                len    <= rx_data[LW-1:0];
                acc    <= rx_data;
                wr_idx <= '0;
              end
            end
          end
          S_PAYLOAD: begin
            if (rcv) begin
              acc    <= chk_add(acc, rx_data);
              wr_idx <= wr_idx + LW'(1);
            end
          end
          S_CHECK: begin
            if (rcv) begin
              if (chk_match) begin
                frame_ok  <= 1'b1;
                rd_idx    <= '0;
                out_valid <= 1'b1;
                out_data  <= buf_rd_data;
                out_last  <= (len == LW'(1));
              end else begin
                err      <= 1'b1;
                err_code <= ERR_CHK;
              end
            end
          end
          S_DRAIN: begin
            // Bytes arriving while draining are dropped, never start a new frame
            if (rcv) ovr <= 1'b1;
            if (xfer) begin
              if (out_last) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
                out_data  <= 8'h00;
                rd_idx    <= '0;
              end else begin
                rd_idx   <= rd_idx + LW'(1);
                out_data <= buf_rd_data;
                out_last <= ((rd_idx + LW'(2)) == len);
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
